data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_lane_align.sv | 25 ++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder: load FSM
// state encoding and the store lane-mask encodings used by the core.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } ld_state_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Only byte, half and word masks are meaningful to the core.
    function automatic logic mask_legal(input logic [3:0] m);
        return (m == MASK_B) || (m == MASK_H) || (m == MASK_W);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment between the core's low-aligned data and the
// word-organised array: store-side mask/data shift, load-side right shift.
module mem_lane_align (
    input  logic [1:0]  st_off,
    input  logic [3:0]  st_mask,
    input  logic [31:0] st_data,
    output logic [3:0]  st_lane_en,
    output logic [31:0] st_lane_data,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    // Store: move mask and data up to the addressed lane; lanes past 3 fall off.
    always_comb begin
        st_lane_en   = st_mask << st_off;
        st_lane_data = st_data << {st_off, 3'b000};
    end

    // Load: bring the addressed byte down to bits [7:0], zero-fill the top.
    always_comb begin
        ld_data = ld_word >> {ld_off, 3'b000};
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory with zero-wait stores and a fixed-latency,
// abortable load path.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no load in flight; accepts read_enable when no store present
// WAIT    | load latched, counting latency down; drops out if request lost
// RESP    | read_valid high for this cycle, read_data carries the result
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [3:0]  write_mask,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        protocol_error
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: READ_LATENCY must be within 1..15");
    end

    logic [31:0]       mem [DEPTH];
    ld_state_t         state;
    logic [3:0]        cnt;
    logic [ADDR_W+1:0] lat_addr;

    logic [ADDR_W-1:0] st_idx;
    logic [ADDR_W-1:0] ld_idx;
    logic [1:0]        ld_off;
    logic [3:0]        lane_en;
    logic [31:0]       lane_data;
    logic [31:0]       ld_aligned;
    logic              unused_addr_hi;

    // Bits above the array index alias; they are deliberately discarded.
    assign unused_addr_hi = ^address[31:ADDR_W+2];
    assign st_idx         = address[ADDR_W+1:2];

    // Load address source: the live bus when accepting straight into RESP,
    // otherwise the address captured at acceptance.
    always_comb begin
        ld_idx = lat_addr[ADDR_W+1:2];
        ld_off = lat_addr[1:0];
        if (state == ST_IDLE) begin
            ld_idx = address[ADDR_W+1:2];
            ld_off = address[1:0];
        end
    end

    mem_lane_align u_align (
        .st_off       (address[1:0]),
        .st_mask      (write_mask),
        .st_data      (write_data),
        .st_lane_en   (lane_en),
        .st_lane_data (lane_data),
        .ld_off       (ld_off),
        .ld_word      (mem[ld_idx]),
        .ld_data      (ld_aligned)
    );

    // Array write port: commit enabled lanes on every store cycle, no reset.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[st_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Load FSM with registered response outputs and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            lat_addr       <= '0;
            read_valid     <= 1'b0;
            read_data      <= '0;
            protocol_error <= 1'b0;
        end else begin
            read_valid <= 1'b0;

            if (write_enable && (read_enable || !mask_legal(write_mask))) begin
                protocol_error <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (read_enable && !write_enable) begin
                        lat_addr <= address[ADDR_W+1:0];
                        cnt      <= LAT_LOAD;
                        if (READ_LATENCY == 1) begin
                            state      <= ST_RESP;
                            read_valid <= 1'b1;
                            read_data  <= ld_aligned;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!read_enable || write_enable) begin
                        // Request withdrawn or store collided: abandon quietly.
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state      <= ST_RESP;
                            read_valid <= 1'b1;
                            read_data  <= ld_aligned;
                        end
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + randomized bench for data_mem_responder. Two instances share
// the store bus (so their arrays stay identical): latency 2 and latency 1.
// Expected load data comes from a byte-addressed reference memory.
module tb_data_mem_responder;

    localparam int ADDR_W = 12;
    localparam int NBYTES = 4 * (2 ** ADDR_W);

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [3:0]  write_mask;
    logic        re0, re1;
    logic [31:0] rd0, rd1;
    logic        rv0, rv1;
    logic        pe0, pe1;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] mbytes [NBYTES];

    data_mem_responder #(.ADDR_W(ADDR_W), .READ_LATENCY(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .write_data     (write_data),
        .write_enable   (write_enable),
        .write_mask     (write_mask),
        .read_enable    (re0),
        .read_data      (rd0),
        .read_valid     (rv0),
        .protocol_error (pe0)
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .READ_LATENCY(1)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .write_data     (write_data),
        .write_enable   (write_enable),
        .write_mask     (write_mask),
        .read_enable    (re1),
        .read_data      (rd1),
        .read_valid     (rv1),
        .protocol_error (pe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bytes at the addressed offset upward within the word.
    function automatic logic [31:0] model_load(input logic [31:0] a);
        logic [31:0] r = '0;
        int base = int'(a[ADDR_W+1:0]);
        int off  = int'(a[1:0]);
        for (int j = 0; j < 4; j++)
            if (off + j < 4) r[8*j +: 8] = mbytes[base + j];
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int base = int'(a[ADDR_W+1:0]);
        int off  = int'(a[1:0]);
        for (int i = 0; i < 4; i++)
            if (m[i] && (off + i < 4)) mbytes[base + i] = d[8*i +: 8];
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        address      = a;
        write_data   = d;
        write_mask   = m;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        model_store(a, d, m);
    endtask

    // Holds read_enable until the response cycle, checks exact pulse timing.
    task automatic do_load(input int sel, input logic [31:0] a, input logic [31:0] exp, input string tag);
        int rl = (sel == 1) ? 1 : 2;
        logic v;
        logic [31:0] d;
        address = a;
        if (sel == 1) re1 = 1'b1; else re0 = 1'b1;
        for (int k = 1; k <= rl + 2; k++) begin
            tick();
            v = (sel == 1) ? rv1 : rv0;
            d = (sel == 1) ? rd1 : rd0;
            chk($sformatf("%s_valid_c%0d", tag, k), {31'b0, v}, {31'b0, (k == rl)});
            if (k == rl) begin
                chk($sformatf("%s_data", tag), d, exp);
                re0 = 1'b0;
                re1 = 1'b0;
            end
            if (k == rl + 1) chk($sformatf("%s_hold", tag), d, exp);
        end
    endtask

    initial begin
        logic [31:0] a, d, e0, e4;
        logic [3:0]  m;
        int          op;

        rst = 1'b0; address = '0; write_data = '0; write_enable = 1'b0;
        write_mask = 4'b0; re0 = 1'b0; re1 = 1'b0;
        tick(); tick(); tick();
        chk("rst_valid0", {31'b0, rv0}, 32'd0);
        chk("rst_data0",  rd0, 32'd0);
        chk("rst_perr0",  {31'b0, pe0}, 32'd0);
        chk("rst_valid1", {31'b0, rv1}, 32'd0);
        chk("rst_data1",  rd1, 32'd0);
        rst = 1'b1;
        tick();

        for (int w = 0; w < 32; w++) do_store(32'(w * 4), $urandom, 4'b1111);

        // Word store then load at latency 2.
        do_store(32'h10, 32'hDEADBEEF, 4'b1111);
        do_load(0, 32'h10, 32'hDEADBEEF, "ld_word");

        // Byte merge into an existing word.
        do_store(32'h10, 32'h11223344, 4'b1111);
        do_store(32'h13, 32'h000000AB, 4'b0001);
        do_load(0, 32'h13, 32'h000000AB, "ld_byte3");
        do_load(0, 32'h10, 32'hAB223344, "byte_merge");

        // Half stores; the one at offset 3 loses its upper byte.
        do_store(32'h12, 32'h5555CAFE, 4'b0011);
        do_load(0, 32'h12, 32'h0000CAFE, "ld_half");
        do_store(32'h13, 32'h00001234, 4'b0011);
        do_load(0, 32'h10, 32'h34FE3344, "half_drop");

        // High address bits alias onto the array.
        do_store(32'hFFFFC020, 32'h0BADF00D, 4'b1111);
        do_load(1, 32'h20, 32'h0BADF00D, "alias");

        // Back-to-back loads at latency 1.
        e0 = model_load(32'h0);
        e4 = model_load(32'h4);
        address = 32'h0; re1 = 1'b1;
        tick();
        chk("b2b_v1", {31'b0, rv1}, 32'd1);
        chk("b2b_d1", rd1, e0);
        address = 32'h4;
        tick();
        chk("b2b_v2", {31'b0, rv1}, 32'd0);
        tick();
        chk("b2b_v3", {31'b0, rv1}, 32'd1);
        chk("b2b_d3", rd1, e4);
        re1 = 1'b0;
        tick();
        chk("b2b_v4", {31'b0, rv1}, 32'd0);

        // Request withdrawn during WAIT.
        address = 32'h8; re0 = 1'b1;
        tick();
        chk("abort_v1", {31'b0, rv0}, 32'd0);
        re0 = 1'b0;
        tick();
        chk("abort_v2", {31'b0, rv0}, 32'd0);
        tick();
        chk("abort_v3", {31'b0, rv0}, 32'd0);
        chk("abort_data_hold", rd0, 32'h34FE3344);
        chk("abort_perr", {31'b0, pe0}, 32'd0);

        // Reset in WAIT abandons the load.
        address = 32'h10; re0 = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstw_valid", {31'b0, rv0}, 32'd0);
        chk("rstw_data",  rd0, 32'd0);
        chk("rstw_perr",  {31'b0, pe0}, 32'd0);
        re0 = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rstw_after_c%0d", k), {31'b0, rv0}, 32'd0);
        end
        do_load(0, 32'h10, 32'h34FE3344, "post_rst");

        // Read and write together: store happens, load does not.
        address = 32'h30; write_data = 32'h13572468; write_mask = 4'b1111;
        write_enable = 1'b1; re0 = 1'b1;
        tick();
        write_enable = 1'b0; re0 = 1'b0;
        model_store(32'h30, 32'h13572468, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rw_valid_c%0d", k), {31'b0, rv0}, 32'd0);
            chk($sformatf("rw_perr_c%0d", k), {31'b0, pe0}, 32'd1);
            tick();
        end
        do_load(0, 32'h30, 32'h13572468, "rw_store");
        chk("rw_perr_sticky", {31'b0, pe0}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rw_perr_cleared", {31'b0, pe0}, 32'd0);

        // Illegal mask still applied, flags error.
        do_store(32'h14, 32'hDDCCBBAA, 4'b0101);
        chk("badmask_perr", {31'b0, pe0}, 32'd1);
        do_load(0, 32'h14, model_load(32'h14), "badmask");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Random stores and loads against the byte model.
        for (int it = 0; it < 60; it++) begin
            a = $urandom;
            a[ADDR_W+1:7] = '0;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                case ($urandom_range(0, 2))
                    0: m = 4'b0001;
                    1: m = 4'b0011;
                    default: m = 4'b1111;
                endcase
                d = $urandom;
                do_store(a, d, m);
            end else begin
                do_load(op - 1, a, model_load(a), $sformatf("rnd%0d", it));
            end
        end
        chk("rnd_perr", {31'b0, pe0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
